// File: rtl/shared_reg_pkg.sv
// ---------------------------------------------------------------------------
// shared_reg_pkg
// Shared definitions for the shared-register arbiter:
//   - arb_state_e  : arbiter FSM states (IDLE / GRANT / DONE)
//   - N_REQ_DEF    : default number of requesters
//   - WIDTH_DEF    : default width of the shared register
//   - LOCK_MAX_DEF : default maximum consecutive locked writes per winner
// ---------------------------------------------------------------------------
package shared_reg_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int LOCK_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector: finds the first set request bit
// at or after rr_ptr, wrapping modulo N_REQ.
// Ports:
//   req        in  [N_REQ-1:0]  request vector
//   rr_ptr     in  [PTR_W-1:0]  highest-priority position (0..N_REQ-1)
//   winner_oh  out [N_REQ-1:0]  one-hot winner (all zero when no request)
//   winner_idx out [PTR_W-1:0]  binary winner index (0 when no request)
//   any_req    out              at least one request bit set
// ---------------------------------------------------------------------------
module rr_picker
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any_req
);

    int         pos;
    logic [PTR_W-1:0] pos_w;
    logic       found;

    // Walk the requesters starting at rr_ptr; the first hit wins.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any_req    = |req;
        found      = 1'b0;
        pos        = 0;
        pos_w      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            pos = int'(rr_ptr) + off;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_w = PTR_W'(pos);
            if (!found && req[pos_w]) begin
                found             = 1'b1;
                winner_oh[pos_w]  = 1'b1;
                winner_idx        = pos_w;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin arbiter guarding one shared register. A request seen in IDLE
// gets a one-cycle registered grant (GRANT); at GRANT's closing edge the
// winner's data is written into q, then DONE pulses ack for one cycle.
// Optional feature (macro SHARED_REG_ARBITER_LOCK_EN): a winner holding
// lock and req is re-granted directly from DONE, up to LOCK_MAX writes.
// Ports:
//   clk    in                   clock, all state on rising edge
//   rst_n  in                   asynchronous active-low reset
//   req    in  [N_REQ-1:0]      per-requester write request (level)
//   wdata  in  [N_REQ*WIDTH-1:0] requester i at [i*WIDTH +: WIDTH]
//   lock   in  [N_REQ-1:0]      grant-retain request (LOCK_EN builds only)
//   gnt    out [N_REQ-1:0]      registered one-hot grant
//   ack    out                  registered one-cycle write-complete pulse
//   q      out [WIDTH-1:0]      shared register contents
//   busy   out                  FSM not in IDLE
// ---------------------------------------------------------------------------
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef SHARED_REG_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);

    // Reject parameter sets the design was not built for.
    if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("shared_reg_arbiter: unsupported parameter set");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] win_q, win_d;

    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;
    logic             retain;
    logic [PTR_W-1:0] ptr_after_win;
    logic [WIDTH-1:0] wdata_lane [N_REQ];

    // Unpack the flat write-data bus into per-requester lanes.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign wdata_lane[gi] = wdata[gi*WIDTH +: WIDTH];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any_req    (any_req)
    );

    assign ptr_after_win = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef SHARED_REG_ARBITER_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // Count holds the number of extra writes already granted to this winner.
    assign retain = lock[win_q] && req[win_q] &&
                    (lock_cnt_q < CNT_W'(LOCK_MAX - 1));

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == DONE) begin
            lock_cnt_d = retain ? lock_cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign retain = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ack_q    <= 1'b0;
            q_q      <= '0;
            rr_ptr_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    win_d   = pick_idx;
                end
            end
            GRANT:   state_d = DONE;
            DONE:    state_d = retain ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. gnt and ack are registered, so they are
    // computed from the state being entered.
    always_comb begin
        gnt_d    = '0;
        ack_d    = 1'b0;
        q_d      = q_q;
        rr_ptr_d = rr_ptr_q;
        if (state_d == GRANT) begin
            gnt_d[win_d] = 1'b1;
        end
        if (state_d == DONE) begin
            ack_d = 1'b1;
        end
        if (state_q == GRANT) begin
            q_d = wdata_lane[win_q];
        end
        if (state_q == DONE && !retain) begin
            rr_ptr_d = ptr_after_win;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign q    = q_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, width of the shared register.
REQ-003 SHALL have parameter LOCK_MAX, default 4, maximum consecutive locked writes per winner.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester write request, level.
REQ-007 SHALL have port wdata  input  N_REQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port lock  input  N_REQ  per-requester grant-retain request; present only with LOCK_EN.
REQ-009 SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-010 SHALL have port ack  output  1  one-cycle write-complete pulse, registered.
REQ-011 SHALL have port q  output  WIDTH  shared register contents.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, DONE.
REQ-014 IDLE: req sampled; if any bit set, winner = first set bit at or after rr_ptr (wrapping modulo N_REQ), gnt[winner]=1 next cycle, state -> GRANT; else stay IDLE, gnt=0.
REQ-015 GRANT: lasts exactly one cycle; at its closing edge q <= wdata[winner]; state -> DONE.
REQ-016 DONE: ack=1 and gnt=0 for exactly one cycle; q holds new value; rr_ptr <= (winner+1) mod N_REQ unless lock retention applies (REQ-025); state -> IDLE.
REQ-017 Latency: req seen in IDLE at edge N -> gnt high cycle N+1 -> q updated and ack high cycle N+2.
REQ-018 Throughput: one write per 3 cycles under continuous requests; no back-to-back grants without passing DONE.
REQ-019 req/wdata ignored outside IDLE, except wdata[winner] sampled at GRANT's closing edge; dropping req during GRANT does not cancel the write.
REQ-020 Simultaneous requests: round-robin from rr_ptr; every continuously-requesting requester granted within N_REQ grants (LOCK_EN off).
REQ-021 rr_ptr wrap: winner N_REQ-1 -> rr_ptr 0.
REQ-022 gnt SHALL never have more than one bit set; gnt and ack never high in the same cycle.
REQ-023 q SHALL change only at GRANT's closing edge or on reset.

Reset
REQ-024 rst_n low SHALL immediately, without clock: state=IDLE, gnt=0, ack=0, busy=0, q=0, rr_ptr=0, lock count=0; an in-flight write is abandoned (q not loaded); first arbitration occurs at the first rising edge after rst_n rises.

Configuration
REQ-025 Macro SHARED_REG_ARBITER_LOCK_EN defined: in DONE, if lock[winner] and req[winner] and lock count < LOCK_MAX-1, next state GRANT with same winner, rr_ptr unchanged, count+1; otherwise normal REQ-016 and count cleared.
REQ-026 Macro undefined: lock port and lock counter absent; behaviour exactly REQ-013..REQ-023.

Structure
REQ-027 Shared package shared_reg_pkg SHALL hold the FSM state enum and default constants N_REQ_DEF, WIDTH_DEF, LOCK_MAX_DEF.
REQ-028 Sub-module rr_picker (combinational: req, rr_ptr -> one-hot winner, any_req) SHALL be instantiated once.

Verification
REQ-029 Reset: rst_n=0 mid-GRANT with wdata=8'hA5 -> gnt=0, q=8'h00 at once, no ack after release.
REQ-030 Single: req=4'b0100, wdata[2]=8'h3C in IDLE -> gnt=4'b0100 next cycle, q=8'h3C and ack=1 one cycle after.
REQ-031 Contention: req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; q sequence equals each winner's wdata.
REQ-032 Wrap: rr_ptr=3, req=4'b1001 -> grant 3 then 0.
REQ-033 Lock (LOCK_EN, LOCK_MAX=4): req=4'b0011, lock[0]=1 held -> requester 0 gets 4 consecutive writes (acks), then requester 1 granted.
REQ-034 Drop: req[1] deasserted during GRANT -> write still completes, ack=1, q=wdata[1].
